// File: rtl/logic_pipe_pkg.sv
// Shared types and constants for the logic_pipe two-stage bitwise pipeline.
package logic_pipe_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 2'd0,
        OP_OR     = 2'd1,
        OP_XOR    = 2'd2,
        OP_ABSORB = 2'd3
    } op_e;

endpackage

// File: rtl/logic_pipe_lane.sv
// logic_lane: combinational bitwise operator between the two pipeline stages.
module logic_lane
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_ABSORB: y = a | (a & b);
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage valid/ready bitwise pipeline with saturating transfer counter.
// Optional output parity is enabled by defining LOGIC_PIPE_PARITY_EN.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_PIPE_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load_c;
    logic             accept_c;
    logic             xfer_c;
    logic [WIDTH-1:0] lane_y;

    // Handshake: in_ready never looks at in_valid, only at pipe state and out_ready.
    always_comb begin
        xfer_c    = s2_valid_q && out_ready;
        s2_load_c = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready  = !s1_valid_q || s2_load_c;
        accept_c  = in_valid && in_ready;
    end

    logic_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .a  (s1_a_q),
        .b  (s1_b_q),
        .op (s1_op_q),
        .y  (lane_y)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        cnt_d      = cnt_q;

        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load_c) begin
            s2_valid_d = 1'b1;
            result_d   = lane_y;
        end else if (xfer_c) begin
            s2_valid_d = 1'b0;
        end

        // Counter sticks at all-ones rather than wrapping.
        if (xfer_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign done_cnt  = cnt_q;

`ifdef LOGIC_PIPE_PARITY_EN
    logic parity_q, parity_d;

    // Parity travels with result so it is always consistent with the held beat.
    always_comb begin
        parity_d = parity_q;
        if (s2_load_c) begin
            parity_d = ^lane_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Testbench for logic_pipe: directed scenarios plus random traffic against a queue-based model.
module tb_logic_pipe;
    import logic_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_a = '0;
    logic [7:0] drv_b = '0;
    op_e        drv_op = OP_AND;
    logic       drv_ordy = 1'b0;

    logic        in_ready, out_valid;
    logic [7:0]  result;
    logic [15:0] done_cnt;
    logic        in_ready2, out_valid2;
    logic [7:0]  result2;
    logic [1:0]  done_cnt2;
`ifdef LOGIC_PIPE_PARITY_EN
    logic parity, parity2;
`endif

    always #5 clk = ~clk;

    logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(drv_valid), .in_ready(in_ready),
        .a(drv_a), .b(drv_b), .op(drv_op), .out_valid(out_valid),
        .out_ready(drv_ordy), .result(result), .done_cnt(done_cnt)
`ifdef LOGIC_PIPE_PARITY_EN
        , .parity(parity)
`endif
    );

    logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(drv_valid), .in_ready(in_ready2),
        .a(drv_a), .b(drv_b), .op(drv_op), .out_valid(out_valid2),
        .out_ready(drv_ordy), .result(result2), .done_cnt(done_cnt2)
`ifdef LOGIC_PIPE_PARITY_EN
        , .parity(parity2)
`endif
    );

    typedef struct {
        logic [7:0] res;
        int         age;
    } ent_t;

    ent_t       q[$];
    logic [7:0] log_q[$];
    int         cnt = 0;
    int         cnt2 = 0;
    logic       last_acc = 1'b0;
    int         n_vec = 0;
    int         n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference operators written from the algebra: absorption a|(a&b) reduces to a.
    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input op_e o);
        case (o)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return x;
        endcase
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        logic exp_ir, exp_ov;
        @(negedge clk);
        exp_ir = (q.size() < 2) || drv_ordy;
        exp_ov = (q.size() > 0) && (q[0].age >= 1);
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("in_ready_c2", 32'(in_ready2), 32'(exp_ir));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("out_valid_c2", 32'(out_valid2), 32'(exp_ov));
        if (exp_ov) begin
            check_eq("result", 32'(result), 32'(q[0].res));
            check_eq("result_c2", 32'(result2), 32'(q[0].res));
`ifdef LOGIC_PIPE_PARITY_EN
            check_eq("parity", 32'(parity), 32'(^q[0].res));
`endif
        end
        check_eq("done_cnt", 32'(done_cnt), 32'(cnt));
        check_eq("done_cnt_c2", 32'(done_cnt2), 32'(cnt2));
        @(posedge clk);
        last_acc = drv_valid && exp_ir;
        if (exp_ov && drv_ordy) begin
            log_q.push_back(q[0].res);
            void'(q.pop_front());
            if (cnt < 65535) cnt++;
            if (cnt2 < 3) cnt2++;
        end
        foreach (q[i]) q[i].age++;
        if (last_acc) q.push_back('{ref_op(drv_a, drv_b, drv_op), 0});
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [7:0] x, input logic [7:0] y, input op_e o);
        drv_valid = v;
        drv_a     = x;
        drv_b     = y;
        drv_op    = o;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_result"}, 32'(result), 32'd0);
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        check_eq({tag, "_done_cnt_c2"}, 32'(done_cnt2), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] exp_log[4];
        int sent;

        // Reset state
        #3;
        check_reset_state("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single AND beat, two-cycle latency
        drv_ordy = 1'b1;
        set_beat(1'b1, 8'hF0, 8'h3C, OP_AND);
        cycle();
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        repeat (3) cycle();
        check_eq("t1_result", 32'(log_q[0]), 32'h30);
        check_eq("t1_cnt", 32'(done_cnt), 32'd1);

        // Four back-to-back beats, one per op
        log_q.delete();
        set_beat(1'b1, 8'hF0, 8'h3C, OP_AND);    cycle();
        set_beat(1'b1, 8'hF0, 8'h3C, OP_OR);     cycle();
        set_beat(1'b1, 8'hF0, 8'h3C, OP_XOR);    cycle();
        set_beat(1'b1, 8'hF0, 8'h3C, OP_ABSORB); cycle();
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        repeat (3) cycle();
        exp_log = '{8'h30, 8'hFC, 8'hCC, 8'hF0};
        check_eq("b2b_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check_eq("b2b_result", 32'(log_q[i]), 32'(exp_log[i]));
        check_eq("sat_c2", 32'(done_cnt2), 32'd3);
        check_eq("cnt_5", 32'(done_cnt), 32'd5);

        // Backpressure: three beats offered with out_ready low
        log_q.delete();
        drv_ordy = 1'b0;
        sent = 0;
        for (int c = 0; c < 20 && sent < 3; c++) begin
            if (c == 4) begin
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_hold", 32'(result), 32'h0A);
                drv_ordy = 1'b1;
            end
            case (sent)
                0: set_beat(1'b1, 8'hAA, 8'h0F, OP_AND);
                1: set_beat(1'b1, 8'h55, 8'h0F, OP_OR);
                default: set_beat(1'b1, 8'hFF, 8'h0F, OP_XOR);
            endcase
            cycle();
            if (last_acc) sent++;
        end
        check_eq("stall_sent", 32'(sent), 32'd3);
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        repeat (4) cycle();
        check_eq("stall_count", 32'(log_q.size()), 32'd3);
        exp_log = '{8'h0A, 8'h5F, 8'hF0, 8'h00};
        for (int i = 0; i < 3 && i < log_q.size(); i++) check_eq("stall_order", 32'(log_q[i]), 32'(exp_log[i]));

        // Parity-relevant beat: odd population count
        log_q.delete();
        set_beat(1'b1, 8'h07, 8'h00, OP_OR);
        cycle();
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        repeat (3) cycle();
        check_eq("par_result", 32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'h07);

        // Reset with two beats in flight
        drv_ordy = 1'b0;
        set_beat(1'b1, 8'h12, 8'h34, OP_XOR); cycle();
        set_beat(1'b1, 8'h56, 8'h78, OP_OR);  cycle();
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        q.delete();
        log_q.delete();
        cnt  = 0;
        cnt2 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv_ordy = 1'b1;
        repeat (4) cycle();
        check_eq("midrst_no_stale", 32'(log_q.size()), 32'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            set_beat(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), op_e'($urandom_range(0, 3)));
            drv_ordy = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        set_beat(1'b0, 8'h00, 8'h00, OP_AND);
        drv_ordy = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
